// File: rtl/ball_shot_ctrl_if.sv
// Shot-controller bus: frame/shot inputs from the game logic, ball position
// and scoring outputs toward the sprite renderer and score display.
interface ball_shot_ctrl_if;
    logic       frame_tick;
    logic       shoot;
    logic [7:0] vx_in;
    logic [7:0] vy_in;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic       in_flight;
    logic [1:0] state;
    logic       score_pulse;
    logic [7:0] score_cnt;

    modport master (
        output frame_tick, shoot, vx_in, vy_in,
        input  ball_x, ball_y, in_flight, state, score_pulse, score_cnt
    );

    modport slave (
        input  frame_tick, shoot, vx_in, vy_in,
        output ball_x, ball_y, in_flight, state, score_pulse, score_cnt
    );
endinterface

// File: rtl/ball_shot_ctrl.sv
// Basketball motion sequencer: integrates a projectile once per video frame
// in 10.4 fixed point, clamps against walls/ceiling/floor, detects baskets
// and keeps a saturating score.
module ball_shot_ctrl #(
    parameter int X0          = 80,
    parameter int Y0          = 400,
    parameter int X_MIN       = 4,
    parameter int X_MAX       = 635,
    parameter int Y_MIN       = 4,
    parameter int FLOOR_Y     = 460,
    parameter int GRAV        = 4,
    parameter int HOOP_X_L    = 540,
    parameter int HOOP_X_R    = 572,
    parameter int HOOP_Y      = 200,
    parameter int REST_FRAMES = 60
) (
    input  logic             clk,
    input  logic             reset_n,
    ball_shot_ctrl_if.slave  bus
);

    localparam int RW = (REST_FRAMES > 64) ? $clog2(REST_FRAMES) : 6;

    // Fixed-point (10.4) positions used for launch, rest and clamping
    localparam logic [13:0] X0_FX    = 14'(X0 * 16);
    localparam logic [13:0] Y0_FX    = 14'(Y0 * 16);
    localparam logic [13:0] XMIN_FX  = 14'(X_MIN * 16);
    localparam logic [13:0] XMAX_FX  = 14'(X_MAX * 16);
    localparam logic [13:0] YMIN_FX  = 14'(Y_MIN * 16);
    localparam logic [13:0] FLOOR_FX = 14'((FLOOR_Y - 4) * 16);

    // Integer-pixel thresholds, signed so off-screen (negative) positions compare correctly
    localparam logic signed [10:0] X_MIN_C   = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_C   = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_C   = 11'(Y_MIN);
    localparam logic signed [10:0] FLOOR_C   = 11'(FLOOR_Y - 4);
    localparam logic signed [10:0] HOOP_XL_C = 11'(HOOP_X_L);
    localparam logic signed [10:0] HOOP_XR_C = 11'(HOOP_X_R);
    localparam logic signed [10:0] HOOP_Y_C  = 11'(HOOP_Y);
    localparam logic [9:0]         HOOP_Y_U  = 10'(HOOP_Y);
    localparam logic signed [11:0] GRAV_C    = 12'(GRAV);
    localparam logic [RW-1:0]      REST_LAST = RW'(REST_FRAMES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FLIGHT = 2'd1,
        ST_REST   = 2'd2
    } state_t;

    state_t               state_r;
    logic [13:0]          px_r;
    logic [13:0]          py_r;
    logic signed [11:0]   vx_r;
    logic signed [11:0]   vy_r;
    logic                 scored_r;
    logic [RW-1:0]        rest_cnt_r;
    logic                 in_flight_r;
    logic                 score_pulse_r;
    logic [7:0]           score_cnt_r;

    logic signed [14:0]   nx_s;
    logic signed [14:0]   ny_s;
    logic signed [10:0]   nx_px_s;
    logic signed [10:0]   ny_px_s;
    logic                 wall_lo_s;
    logic                 wall_hi_s;
    logic                 ceil_hit_s;
    logic                 floor_hit_s;
    logic                 basket_s;

    // Sign-extend an 8-bit launch velocity to the 12-bit internal velocity width
    function automatic logic signed [11:0] sext8(input logic [7:0] v);
        return {{4{v[7]}}, v};
    endfunction

    // Candidate next position and the collision/basket conditions it implies
    always_comb begin
        nx_s        = $signed({1'b0, px_r}) + $signed({{3{vx_r[11]}}, vx_r});
        ny_s        = $signed({1'b0, py_r}) + $signed({{3{vy_r[11]}}, vy_r});
        nx_px_s     = nx_s[14:4];
        ny_px_s     = ny_s[14:4];
        wall_lo_s   = (nx_px_s < X_MIN_C);
        wall_hi_s   = (nx_px_s > X_MAX_C);
        ceil_hit_s  = (ny_px_s < Y_MIN_C);
        floor_hit_s = (ny_px_s >= FLOOR_C);
        basket_s    = (vy_r > 12'sd0) && (py_r[13:4] < HOOP_Y_U) &&
                      (ny_px_s >= HOOP_Y_C) && (nx_px_s >= HOOP_XL_C) &&
                      (nx_px_s <= HOOP_XR_C) && !scored_r;
    end

    // Shot sequencer: launch, per-frame integration with clamps, rest timer
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= ST_IDLE;
            px_r          <= X0_FX;
            py_r          <= Y0_FX;
            vx_r          <= 12'sd0;
            vy_r          <= 12'sd0;
            scored_r      <= 1'b0;
            rest_cnt_r    <= {RW{1'b0}};
            in_flight_r   <= 1'b0;
            score_pulse_r <= 1'b0;
            score_cnt_r   <= 8'd0;
        end else begin
            score_pulse_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    px_r <= X0_FX;
                    py_r <= Y0_FX;
                    if (bus.shoot) begin
                        vx_r        <= sext8(bus.vx_in);
                        vy_r        <= 12'sd0 - sext8(bus.vy_in);
                        scored_r    <= 1'b0;
                        in_flight_r <= 1'b1;
                        state_r     <= ST_FLIGHT;
                    end
                end
                ST_FLIGHT: begin
                    if (bus.frame_tick) begin
                        if (wall_lo_s) begin
                            px_r <= XMIN_FX;
                            vx_r <= 12'sd0 - vx_r;
                        end else if (wall_hi_s) begin
                            px_r <= XMAX_FX;
                            vx_r <= 12'sd0 - vx_r;
                        end else begin
                            px_r <= nx_s[13:0];
                        end
                        // Ceiling reflection takes the place of gravity on that frame
                        if (ceil_hit_s) begin
                            py_r <= YMIN_FX;
                            vy_r <= 12'sd0 - vy_r;
                        end else begin
                            py_r <= ny_s[13:0];
                            vy_r <= vy_r + GRAV_C;
                        end
                        if (basket_s) begin
                            score_pulse_r <= 1'b1;
                            scored_r      <= 1'b1;
                            if (score_cnt_r != 8'hFF) begin
                                score_cnt_r <= score_cnt_r + 8'd1;
                            end
                        end
                        // Floor landing overrides the velocity updates above
                        if (floor_hit_s) begin
                            py_r        <= FLOOR_FX;
                            vx_r        <= 12'sd0;
                            vy_r        <= 12'sd0;
                            rest_cnt_r  <= {RW{1'b0}};
                            in_flight_r <= 1'b0;
                            state_r     <= ST_REST;
                        end
                    end
                end
                ST_REST: begin
                    if (bus.frame_tick) begin
                        if (rest_cnt_r == REST_LAST) begin
                            px_r    <= X0_FX;
                            py_r    <= Y0_FX;
                            state_r <= ST_IDLE;
                        end else begin
                            rest_cnt_r <= rest_cnt_r + {{(RW-1){1'b0}}, 1'b1};
                        end
                    end
                end
                default: begin
                    px_r        <= X0_FX;
                    py_r        <= Y0_FX;
                    in_flight_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ball_x      = px_r[13:4];
    assign bus.ball_y      = py_r[13:4];
    assign bus.in_flight   = in_flight_r;
    assign bus.state       = state_r;
    assign bus.score_pulse = score_pulse_r;
    assign bus.score_cnt   = score_cnt_r;

endmodule

// File: tb/tb_ball_shot_ctrl.sv
// Self-checking bench for ball_shot_ctrl: directed scenarios plus randomized
// shots compared against an integer-arithmetic trajectory model.
module tb_ball_shot_ctrl;

    logic clk = 1'b0;
    logic reset_n;

    ball_shot_ctrl_if bus0 ();
    ball_shot_ctrl_if bus1 ();
    ball_shot_ctrl_if bus2 ();

    ball_shot_ctrl dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));
    ball_shot_ctrl #(.X0(556), .HOOP_Y(300)) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));
    ball_shot_ctrl #(.X0(300), .Y0(40)) dut2 (.clk(clk), .reset_n(reset_n), .bus(bus2));

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // Per-instance parameters and model state (positions in 1/16 px)
    int p_x0[3] = '{80, 556, 300};
    int p_y0[3] = '{400, 400, 40};
    int p_hy[3] = '{200, 300, 200};
    int m_st[3], m_px[3], m_py[3], m_vx[3], m_vy[3], m_rest[3], m_cnt[3];
    bit m_scored[3], m_pulse[3];

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_px[i] = p_x0[i] * 16; m_py[i] = p_y0[i] * 16;
            m_vx[i] = 0; m_vy[i] = 0; m_rest[i] = 0; m_cnt[i] = 0;
            m_scored[i] = 1'b0; m_pulse[i] = 1'b0;
        end
    endtask

    task automatic model_step(input int i, input bit tick, input bit sh, input int vxi, input int vyi);
        int nx, ny, bx, by;
        bit basket;
        m_pulse[i] = 1'b0;
        case (m_st[i])
            0: begin
                m_px[i] = p_x0[i] * 16; m_py[i] = p_y0[i] * 16;
                if (sh) begin
                    m_vx[i] = vxi; m_vy[i] = -vyi; m_scored[i] = 1'b0; m_st[i] = 1;
                end
            end
            1: if (tick) begin
                nx = m_px[i] + m_vx[i]; ny = m_py[i] + m_vy[i];
                bx = nx >>> 4; by = ny >>> 4;
                basket = (m_vy[i] > 0) && ((m_py[i] >>> 4) < p_hy[i]) && (by >= p_hy[i]) &&
                         (bx >= 540) && (bx <= 572) && !m_scored[i];
                if (bx < 4) begin m_px[i] = 64; m_vx[i] = -m_vx[i]; end
                else if (bx > 635) begin m_px[i] = 635 * 16; m_vx[i] = -m_vx[i]; end
                else m_px[i] = nx;
                if (by < 4) begin m_py[i] = 64; m_vy[i] = -m_vy[i]; end
                else begin m_py[i] = ny; m_vy[i] = m_vy[i] + 4; end
                if (basket) begin
                    m_pulse[i] = 1'b1; m_scored[i] = 1'b1;
                    if (m_cnt[i] < 255) m_cnt[i]++;
                end
                if (by >= 456) begin
                    m_py[i] = 456 * 16; m_vx[i] = 0; m_vy[i] = 0; m_rest[i] = 0; m_st[i] = 2;
                end
            end
            2: if (tick) begin
                if (m_rest[i] == 59) begin
                    m_st[i] = 0; m_px[i] = p_x0[i] * 16; m_py[i] = p_y0[i] * 16;
                end else m_rest[i]++;
            end
            default: m_st[i] = 0;
        endcase
    endtask

    function automatic logic [31:0] mvec(input int i);
        return {10'(m_px[i] >>> 4), 10'(m_py[i] >>> 4), 2'(m_st[i]), (m_st[i] == 1), m_pulse[i], 8'(m_cnt[i])};
    endfunction

    // One clock: drive inputs, let the edge sample them, advance the model
    task automatic step(input bit tick, input logic [2:0] sh, input logic [7:0] vx, input logic [7:0] vy);
        bus0.frame_tick = tick; bus0.shoot = sh[0]; bus0.vx_in = vx; bus0.vy_in = vy;
        bus1.frame_tick = tick; bus1.shoot = sh[1]; bus1.vx_in = vx; bus1.vy_in = vy;
        bus2.frame_tick = tick; bus2.shoot = sh[2]; bus2.vx_in = vx; bus2.vy_in = vy;
        @(posedge clk);
        #1;
        model_step(0, tick, sh[0], int'($signed(vx)), int'($signed(vy)));
        model_step(1, tick, sh[1], int'($signed(vx)), int'($signed(vy)));
        model_step(2, tick, sh[2], int'($signed(vx)), int'($signed(vy)));
        bus0.frame_tick = 1'b0; bus0.shoot = 1'b0;
        bus1.frame_tick = 1'b0; bus1.shoot = 1'b0;
        bus2.frame_tick = 1'b0; bus2.shoot = 1'b0;
    endtask

    // Tick every clock until every instance is back in IDLE, bounded
    task automatic run_idle(input int bound, output bit ok, output int p1);
        int n = 0;
        p1 = 0;
        while ((m_st[0] != 0 || m_st[1] != 0 || m_st[2] != 0) && n < bound) begin
            step(1'b1, 3'b000, 8'd0, 8'd0);
            if (bus1.score_pulse) p1++;
            n++;
        end
        ok = (m_st[0] == 0 && m_st[1] == 0 && m_st[2] == 0);
    endtask

    task automatic test_reset();
        logic [31:0] e0, e1;
        e0 = {10'd80, 10'd400, 2'd0, 1'b0, 1'b0, 8'd0};
        e1 = {10'd556, 10'd400, 2'd0, 1'b0, 1'b0, 8'd0};
        n_checks++;
        if ({bus0.ball_x, bus0.ball_y, bus0.state, bus0.in_flight, bus0.score_pulse, bus0.score_cnt} !== e0) begin
            n_fails++; $display("FAIL reset0: got %h want %h", {bus0.ball_x, bus0.ball_y, bus0.state, bus0.in_flight, bus0.score_pulse, bus0.score_cnt}, e0);
        end
        n_checks++;
        if ({bus1.ball_x, bus1.ball_y, bus1.state, bus1.in_flight, bus1.score_pulse, bus1.score_cnt} !== e1) begin
            n_fails++; $display("FAIL reset1: got %h want %h", {bus1.ball_x, bus1.ball_y, bus1.state, bus1.in_flight, bus1.score_pulse, bus1.score_cnt}, e1);
        end
    endtask

    task automatic test_vertical();
        bit ok; int p;
        step(1'b0, 3'b001, 8'd0, 8'd64);
        n_checks++;
        if (bus0.state !== 2'd1 || bus0.in_flight !== 1'b1) begin
            n_fails++; $display("FAIL vert_launch: state %0d in_flight %0b want 1 1", bus0.state, bus0.in_flight);
        end
        step(1'b1, 3'b000, 8'd0, 8'd0);
        n_checks++;
        if (bus0.ball_y !== 10'd396 || bus0.ball_x !== 10'd80) begin
            n_fails++; $display("FAIL vert_tick1: x %0d y %0d want 80 396", bus0.ball_x, bus0.ball_y);
        end
        step(1'b1, 3'b000, 8'd0, 8'd0);
        n_checks++;
        if (bus0.ball_y !== 10'd392 || bus0.ball_x !== 10'd80) begin
            n_fails++; $display("FAIL vert_tick2: x %0d y %0d want 80 392", bus0.ball_x, bus0.ball_y);
        end
        run_idle(400, ok, p);
        n_checks++;
        if (!ok || bus0.state !== 2'd0) begin
            n_fails++; $display("FAIL vert_settle: state %0d want 0", bus0.state);
        end
    endtask

    task automatic test_drop();
        int ey, es;
        step(1'b0, 3'b001, 8'd0, 8'd0);
        for (int n = 1; n <= 22; n++) begin
            step(1'b1, 3'b000, 8'd0, 8'd0);
            ey = (n < 22) ? 400 + (n * (n - 1)) / 8 : 456;
            es = (n < 22) ? 1 : 2;
            n_checks++;
            if (bus0.ball_y !== 10'(ey) || bus0.state !== 2'(es) || bus0.ball_x !== 10'd80) begin
                n_fails++; $display("FAIL drop_tick%0d: y %0d state %0d x %0d want %0d %0d 80", n, bus0.ball_y, bus0.state, bus0.ball_x, ey, es);
            end
        end
        for (int k = 1; k <= 60; k++) begin
            step(1'b1, 3'b000, 8'd0, 8'd0);
            ey = (k < 60) ? 456 : 400;
            es = (k < 60) ? 2 : 0;
            n_checks++;
            if (bus0.ball_y !== 10'(ey) || bus0.state !== 2'(es)) begin
                n_fails++; $display("FAIL drop_rest%0d: y %0d state %0d want %0d %0d", k, bus0.ball_y, bus0.state, ey, es);
            end
        end
    endtask

    task automatic test_basket();
        int pulses = 0, n = 0;
        logic [9:0] prev_y, yb, ya;
        yb = 10'd0; ya = 10'd0;
        step(1'b0, 3'b010, 8'd0, 8'd127);
        while (m_st[1] != 0 && n < 400) begin
            prev_y = bus1.ball_y;
            step(1'b1, 3'b000, 8'd0, 8'd0);
            if (bus1.score_pulse) begin pulses++; yb = prev_y; ya = bus1.ball_y; end
            n++;
        end
        n_checks++;
        if (pulses != 1) begin
            n_fails++; $display("FAIL basket_pulses: got %0d want 1", pulses);
        end
        n_checks++;
        if (!(yb < 10'd300 && ya >= 10'd300)) begin
            n_fails++; $display("FAIL basket_crossing: y %0d -> %0d want downward across 300", yb, ya);
        end
        n_checks++;
        if (bus1.score_cnt !== 8'd1 || bus1.state !== 2'd0) begin
            n_fails++; $display("FAIL basket_count: cnt %0d state %0d want 1 0", bus1.score_cnt, bus1.state);
        end
    endtask

    task automatic test_wall();
        bit ok; int p, ex;
        step(1'b0, 3'b010, 8'd127, 8'd127);
        for (int n = 1; n <= 13; n++) begin
            step(1'b1, 3'b000, 8'd0, 8'd0);
            ex = (n <= 10) ? (8896 + 127 * n) / 16 : (n == 11) ? 635 : (n == 12) ? 627 : 619;
            n_checks++;
            if (bus1.ball_x !== 10'(ex)) begin
                n_fails++; $display("FAIL wall_tick%0d: x %0d want %0d", n, bus1.ball_x, ex);
            end
        end
        run_idle(400, ok, p);
        n_checks++;
        if (!ok || bus1.state !== 2'd0) begin
            n_fails++; $display("FAIL wall_settle: state %0d want 0", bus1.state);
        end
    endtask

    task automatic test_gating();
        bit ok; int p, n = 0;
        step(1'b0, 3'b001, 8'd20, 8'd100);
        repeat (3) step(1'b1, 3'b000, 8'd0, 8'd0);
        step(1'b0, 3'b001, 8'hCE, 8'd10);
        n_checks++;
        if (bus0.state !== 2'd1) begin
            n_fails++; $display("FAIL gate_flight_state: %0d want 1", bus0.state);
        end
        step(1'b1, 3'b000, 8'd0, 8'd0);
        n_checks++;
        if (bus0.ball_x !== 10'(m_px[0] >>> 4) || bus0.ball_y !== 10'(m_py[0] >>> 4)) begin
            n_fails++; $display("FAIL gate_flight_pos: %0d,%0d want %0d,%0d", bus0.ball_x, bus0.ball_y, m_px[0] >>> 4, m_py[0] >>> 4);
        end
        while (m_st[0] != 2 && n < 300) begin step(1'b1, 3'b000, 8'd0, 8'd0); n++; end
        step(1'b0, 3'b001, 8'd5, 8'd5);
        n_checks++;
        if (bus0.state !== 2'd2) begin
            n_fails++; $display("FAIL gate_rest_state: %0d want 2", bus0.state);
        end
        step(1'b1, 3'b000, 8'd0, 8'd0);
        n_checks++;
        if (bus0.state !== 2'd2 || bus0.ball_y !== 10'd456) begin
            n_fails++; $display("FAIL gate_rest_hold: state %0d y %0d want 2 456", bus0.state, bus0.ball_y);
        end
        run_idle(400, ok, p);
        n_checks++;
        if (!ok || bus0.state !== 2'd0) begin
            n_fails++; $display("FAIL gate_settle: state %0d want 0", bus0.state);
        end
    endtask

    task automatic test_saturation();
        bit ok; int p, shots = 0;
        while (m_cnt[1] < 255 && shots < 300) begin
            step(1'b0, 3'b010, 8'd0, 8'd127);
            run_idle(400, ok, p);
            shots++;
        end
        n_checks++;
        if (bus1.score_cnt !== 8'd255) begin
            n_fails++; $display("FAIL sat_preload: cnt %0d want 255", bus1.score_cnt);
        end
        step(1'b0, 3'b010, 8'd0, 8'd127);
        run_idle(400, ok, p);
        n_checks++;
        if (p != 1 || bus1.score_cnt !== 8'd255) begin
            n_fails++; $display("FAIL sat_hold: pulses %0d cnt %0d want 1 255", p, bus1.score_cnt);
        end
    endtask

    task automatic test_random();
        logic [31:0] d0, d1, d2;
        for (int c = 0; c < 3000; c++) begin
            step($urandom_range(0, 2) != 0,
                 {$urandom_range(0, 25) == 0, $urandom_range(0, 25) == 0, $urandom_range(0, 25) == 0},
                 8'($urandom), 8'($urandom));
            d0 = {bus0.ball_x, bus0.ball_y, bus0.state, bus0.in_flight, bus0.score_pulse, bus0.score_cnt};
            d1 = {bus1.ball_x, bus1.ball_y, bus1.state, bus1.in_flight, bus1.score_pulse, bus1.score_cnt};
            d2 = {bus2.ball_x, bus2.ball_y, bus2.state, bus2.in_flight, bus2.score_pulse, bus2.score_cnt};
            n_checks++;
            if (d0 !== mvec(0)) begin n_fails++; $display("FAIL rand0 cyc %0d: got %h want %h", c, d0, mvec(0)); end
            n_checks++;
            if (d1 !== mvec(1)) begin n_fails++; $display("FAIL rand1 cyc %0d: got %h want %h", c, d1, mvec(1)); end
            n_checks++;
            if (d2 !== mvec(2)) begin n_fails++; $display("FAIL rand2 cyc %0d: got %h want %h", c, d2, mvec(2)); end
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d0, d1, e0, e1;
        bit ok; int p;
        run_idle(400, ok, p);
        step(1'b0, 3'b011, 8'd10, 8'd90);
        repeat (5) step(1'b1, 3'b000, 8'd0, 8'd0);
        #2 reset_n = 1'b0;
        #1;
        e0 = {10'd80, 10'd400, 2'd0, 1'b0, 1'b0, 8'd0};
        e1 = {10'd556, 10'd400, 2'd0, 1'b0, 1'b0, 8'd0};
        d0 = {bus0.ball_x, bus0.ball_y, bus0.state, bus0.in_flight, bus0.score_pulse, bus0.score_cnt};
        d1 = {bus1.ball_x, bus1.ball_y, bus1.state, bus1.in_flight, bus1.score_pulse, bus1.score_cnt};
        n_checks++;
        if (d0 !== e0) begin n_fails++; $display("FAIL async_reset0: got %h want %h", d0, e0); end
        n_checks++;
        if (d1 !== e1) begin n_fails++; $display("FAIL async_reset1: got %h want %h", d1, e1); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        reset_n = 1'b0;
        bus0.frame_tick = 1'b0; bus0.shoot = 1'b0; bus0.vx_in = 8'd0; bus0.vy_in = 8'd0;
        bus1.frame_tick = 1'b0; bus1.shoot = 1'b0; bus1.vx_in = 8'd0; bus1.vy_in = 8'd0;
        bus2.frame_tick = 1'b0; bus2.shoot = 1'b0; bus2.vx_in = 8'd0; bus2.vy_in = 8'd0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        test_reset();
        test_vertical();
        test_drop();
        test_basket();
        test_wall();
        test_gating();
        test_saturation();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/ball_shot_ctrl.md
# ball_shot_ctrl

Frame-rate motion sequencer for the basketball sprite. It accepts a shot command with an initial velocity and integrates a projectile trajectory once per video frame in 10.4 fixed point. It clamps the ball against the floor, ceiling and side walls, and detects the ball falling through the hoop window. It drives the `ball_x`/`ball_y` centre coordinates consumed by the sprite renderer and keeps a saturating score count.

## Interface
- `X0`, 80: launch/rest centre x (px)
- `Y0`, 400: launch/rest centre y (px)
- `X_MIN`, 4 / `X_MAX`, 635: allowed centre-x range (px)
- `Y_MIN`, 4: minimum centre y (ceiling)
- `FLOOR_Y`, 460: floor line; resting centre y is `FLOOR_Y-4`
- `GRAV`, 4: gravity, 1/16 px per frame²
- `HOOP_X_L`, 540 / `HOOP_X_R`, 572 / `HOOP_Y`, 200: hoop window (inclusive x, crossing line y)
- `REST_FRAMES`, 60: frames held at rest before re-arming
- `clk`, in, 1: system clock
- `reset_n`, in, 1: asynchronous active-low reset
- `frame_tick`, in, 1: one-clk pulse per frame, at start of vertical blank
- `shoot`, in, 1: one-clk debounced shot request
- `vx_in`, in, 8: signed initial x velocity, 1/16 px/frame, + = right
- `vy_in`, in, 8: signed initial y velocity, 1/16 px/frame, + = up
- `ball_x`, out, 10: ball centre x (integer px)
- `ball_y`, out, 10: ball centre y (integer px)
- `in_flight`, out, 1: high in FLIGHT
- `state`, out, 2: 0 IDLE, 1 FLIGHT, 2 REST
- `score_pulse`, out, 1: one-clk pulse on a basket
- `score_cnt`, out, 8: baskets since reset, saturates at 255

## Operation
**Internal registers**
- `px`, `py`: unsigned 14 bit, 10.4 format.
- `vx`, `vy`: signed 12 bit; internal `vy` is positive = down.
- `scored`: 1-bit flag.
- `rest_cnt`: 6+ bit counter.

**IDLE**
- Hold `px = X0<<4`, `py = Y0<<4`.
- On `shoot`: `vx <= sext(vx_in)`, `vy <= -sext(vy_in)`, `scored <= 0`, go to FLIGHT.

**FLIGHT**, on each `frame_tick`:
- Compute `nx = px + vx` and `ny = py + vy` in 15-bit signed, using the pre-update velocities. Then `vy <= vy + GRAV`.
- **Wall:** if `nx>>4 < X_MIN` or `> X_MAX`, clamp `px` to that bound (fraction 0) and set `vx <= -vx`.
- **Ceiling:** if `ny>>4 < Y_MIN`, clamp `py = Y_MIN<<4` and set `vy <= -vy` (this replaces the gravity add on that tick).
- **Score:** a basket requires all of the following:
  - pre-update `vy > 0`;
  - `py>>4 < HOOP_Y` and `ny>>4 >= HOOP_Y`;
  - `HOOP_X_L <= nx>>4 <= HOOP_X_R`;
  - `!scored`.
- On a basket: assert `score_pulse`, increment `score_cnt` (saturating at 255), set `scored <= 1`. At most one basket per shot.
- **Floor:** if `ny>>4 >= FLOOR_Y-4`, clamp `py = (FLOOR_Y-4)<<4`, zero `vx`/`vy`, clear `rest_cnt`, go to REST.
- Score and floor may fire on the same tick; both take effect.
- `shoot` is ignored in FLIGHT.

**REST**
- On each `frame_tick`, `rest_cnt++`.
- When `rest_cnt == REST_FRAMES-1` on a tick, go to IDLE; the position snaps back to X0/Y0.
- `shoot` is ignored in REST.

**Reset**
- Asynchronous; takes effect immediately, including mid-flight.
- Values: state IDLE, `ball_x = X0`, `ball_y = Y0`, `score_cnt = 0`, `score_pulse = 0`, `in_flight = 0`, velocities 0, `scored = 0`.

## Timing
- All outputs are registered; no combinational input-to-output path.
- `shoot` in IDLE: `state`/`in_flight` change on the next clk edge. Integration starts on the first `frame_tick` after that edge.
- If `shoot` and `frame_tick` coincide in IDLE, the tick does not move the ball.
- Position, clamp and state updates for a `frame_tick` are visible on the edge that samples the tick, i.e. 1 clk latency.
- `score_pulse` is high for exactly the cycle following the sampled tick.
- `ball_x = px[13:4]` and `ball_y = py[13:4]`. They change only on `frame_tick` or a state change to IDLE, so they are stable for the whole active video period.
- Back-to-back `frame_tick`s on consecutive clocks must each be integrated.

## Test plan
- **Reset:** pulse `reset_n` low mid-flight → all outputs return to reset values on that edge without a clk; `score_cnt = 0`.
- **Vertical shot:** `vx_in=0`, `vy_in=+64`, then ticks → `ball_y` reads 396, 392 after ticks 1 and 2; `ball_x` stays 80.
- **Drop:** `vx_in=0`, `vy_in=0` → after tick n, `ball_y = 400 + floor(n(n-1)/8)`. Tick 22 clamps to 456 and enters REST. After 60 more ticks the state is IDLE with `ball_y = 400`.
- **Wall bounce:** `vx_in=+127`, `vy_in=+127` → the tick where `ball_x` would exceed 635 shows 635; subsequent ticks show decreasing `ball_x`.
- **Basket:** override `X0=556`, `HOOP_Y=300`; shoot `vx_in=0`, `vy_in=+127` → no pulse on the upward crossing. Exactly one `score_pulse` on the downward crossing of y=300, and `score_cnt = 1`.
- **Shot gating and saturation:**
  - Pulse `shoot` during FLIGHT and REST → ignored.
  - Preload `score_cnt = 255` via repeated baskets, then score again → `score_cnt` stays 255 and `score_pulse` still asserts.
